vx_vec_wb_serializer: RTL and testbench

- Sits directly upstream of the writeback interface (master side), between the vector execute unit and the commit/register-file stage.
- Accepts one complete vector result per handshake: up to NUM_LANES register lanes, each NUM_THREADS x XLEN.
- Emits one writeback beat per active lane, tagged with is_vec, vd, vd_lane_id, sop/eop and vd_is_last.
- Yields the output slot to the scalar path whenever wb_stall is asserted.

---
 rtl/vx_vec_wb_serializer.sv | 231 +++++++++++++++++++++++
 tb/tb_vx_vec_wb_serializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_vec_wb_serializer.sv
// vx_vec_wb_serializer
// Takes a whole vector result in a single handshake and emits it as one
// writeback beat per active register lane, in ascending lane order.
// The scalar path takes the writeback slot whenever wb_stall is high.
// Optional build macro: VX_VEC_WB_PERF_EN adds the perf_beats and
// perf_stall_cycles counters. With the macro undefined the ports and
// counters are absent and the datapath is the same.
module vx_vec_wb_serializer #(
   parameter int NUM_THREADS = 4,
   parameter int XLEN        = 32,
   parameter int NUM_LANES   = 8,
   parameter int NR_BITS     = 6,
   parameter int UUID_WIDTH  = 44,
   parameter int ISSUE_WIS_W = 2,
   parameter int PC_BITS     = 30
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  vec_in_valid,
   output logic                                  vec_in_ready,
   input  logic [UUID_WIDTH-1:0]                 vec_in_uuid,
   input  logic [ISSUE_WIS_W-1:0]                vec_in_wis,
   input  logic [NUM_THREADS-1:0]                vec_in_tmask,
   input  logic [PC_BITS-1:0]                    vec_in_PC,
   input  logic [NR_BITS-1:0]                    vec_in_vd,
   input  logic [NUM_LANES-1:0]                  vec_in_lmask,
   input  logic [NUM_LANES*NUM_THREADS*XLEN-1:0] vec_in_data,
   input  logic                                  wb_stall,
   output logic                                  wb_valid,
   output logic [UUID_WIDTH-1:0]                 wb_uuid,
   output logic [ISSUE_WIS_W-1:0]                wb_wis,
   output logic [NUM_THREADS-1:0]                wb_tmask,
   output logic [PC_BITS-1:0]                    wb_PC,
   output logic [NR_BITS-1:0]                    wb_rd,
   output logic [NUM_THREADS*XLEN-1:0]           wb_data,
   output logic                                  wb_sop,
   output logic                                  wb_eop,
   output logic                                  wb_is_vec,
   output logic [NR_BITS-1:0]                    wb_vd,
   output logic [$clog2(NUM_LANES)-1:0]          wb_vd_lane_id,
   output logic [$clog2(NUM_LANES)-1:0]          wb_vd_is_last
`ifdef VX_VEC_WB_PERF_EN
   ,
   output logic [31:0]                           perf_beats,
   output logic [31:0]                           perf_stall_cycles
`endif
);

   localparam int LANEID_BITS = $clog2(NUM_LANES);
   localparam int LANE_W      = NUM_THREADS * XLEN;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // Index of the lowest set bit; 0 for an empty mask.
   function automatic logic [LANEID_BITS-1:0] lowest_set(input logic [NUM_LANES-1:0] mask);
      logic [LANEID_BITS-1:0] idx;
      idx = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = LANEID_BITS'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Index of the highest set bit; 0 for an empty mask.
   function automatic logic [LANEID_BITS-1:0] highest_set(input logic [NUM_LANES-1:0] mask);
      logic [LANEID_BITS-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (mask[i]) begin
            idx = LANEID_BITS'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   logic [0:0]                          state_q, state_d;
   logic [UUID_WIDTH-1:0]               uuid_q, uuid_d;
   logic [ISSUE_WIS_W-1:0]              wis_q, wis_d;
   logic [NUM_THREADS-1:0]              tmask_q, tmask_d;
   logic [PC_BITS-1:0]                  pc_q, pc_d;
   logic [NR_BITS-1:0]                  vd_q, vd_d;
   logic [NUM_LANES-1:0]                pend_q, pend_d;
   logic [NUM_LANES*LANE_W-1:0]         data_q, data_d;
   logic [LANEID_BITS-1:0]              ptr_q, ptr_d;
   logic [LANEID_BITS-1:0]              last_q, last_d;
   logic                                first_q, first_d;

   logic                                fire_s;
   logic                                last_beat_s;
   logic                                accept_s;
   logic [NUM_LANES-1:0]                cur_bit_s;
   logic [NUM_LANES-1:0]                pend_left_s;

   // Beat issue, final-beat detection and the input handshake.
   always_comb begin
      fire_s      = (state_q == ST_SEND) && !wb_stall;
      last_beat_s = fire_s && (ptr_q == last_q);
      accept_s    = vec_in_valid && ((state_q == ST_IDLE) || last_beat_s);
      cur_bit_s   = {{(NUM_LANES-1){1'b0}}, 1'b1} << ptr_q;
      pend_left_s = pend_q & ~cur_bit_s;
   end

   // Next-state: capture on accept, otherwise advance to the next pending lane on issue.
   always_comb begin
      state_d = state_q;
      uuid_d  = uuid_q;
      wis_d   = wis_q;
      tmask_d = tmask_q;
      pc_d    = pc_q;
      vd_d    = vd_q;
      pend_d  = pend_q;
      data_d  = data_q;
      ptr_d   = ptr_q;
      last_d  = last_q;
      first_d = first_q;
      if (accept_s) begin
         uuid_d  = vec_in_uuid;
         wis_d   = vec_in_wis;
         tmask_d = vec_in_tmask;
         pc_d    = vec_in_PC;
         vd_d    = vec_in_vd;
         pend_d  = vec_in_lmask;
         data_d  = vec_in_data;
         ptr_d   = lowest_set(vec_in_lmask);
         last_d  = highest_set(vec_in_lmask);
         first_d = 1'b1;
         // An empty lane mask completes the handshake without producing beats.
         if (vec_in_lmask != {NUM_LANES{1'b0}}) begin
            state_d = ST_SEND;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (fire_s) begin
         pend_d  = pend_left_s;
         ptr_d   = lowest_set(pend_left_s);
         first_d = 1'b0;
         if (last_beat_s) begin
            state_d = ST_IDLE;
         end else begin
            state_d = ST_SEND;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and capture registers; reset drops any packet in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         uuid_q  <= '0;
         wis_q   <= '0;
         tmask_q <= '0;
         pc_q    <= '0;
         vd_q    <= '0;
         pend_q  <= '0;
         data_q  <= '0;
         ptr_q   <= '0;
         last_q  <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         uuid_q  <= uuid_d;
         wis_q   <= wis_d;
         tmask_q <= tmask_d;
         pc_q    <= pc_d;
         vd_q    <= vd_d;
         pend_q  <= pend_d;
         data_q  <= data_d;
         ptr_q   <= ptr_d;
         last_q  <= last_d;
         first_q <= first_d;
      end
   end

   assign vec_in_ready  = (state_q == ST_IDLE) || last_beat_s;
   assign wb_valid      = fire_s;
   assign wb_is_vec     = fire_s;
   assign wb_sop        = fire_s && first_q;
   assign wb_eop        = last_beat_s;
   assign wb_uuid       = uuid_q;
   assign wb_wis        = wis_q;
   assign wb_tmask      = tmask_q;
   assign wb_PC         = pc_q;
   assign wb_rd         = {NR_BITS{1'b0}};
   assign wb_vd         = vd_q;
   assign wb_vd_lane_id = ptr_q;
   assign wb_vd_is_last = last_q;
   assign wb_data       = data_q[int'(ptr_q) * LANE_W +: LANE_W];

`ifdef VX_VEC_WB_PERF_EN
   logic [31:0] perf_beats_q, perf_beats_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Free-running event counters, wrapping modulo 2^32.
   always_comb begin
      if (fire_s) begin
         perf_beats_d = perf_beats_q + 32'd1;
      end else begin
         perf_beats_d = perf_beats_q;
      end
      if ((state_q == ST_SEND) && wb_stall) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end else begin
         perf_stall_d = perf_stall_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_beats_q <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         perf_beats_q <= perf_beats_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_beats        = perf_beats_q;
   assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_vx_vec_wb_serializer.sv
// Self-checking bench for vx_vec_wb_serializer: directed test-plan
// scenarios followed by randomized traffic, checked against a
// beat-queue reference model.
module tb_vx_vec_wb_serializer;

   localparam int NT  = 4;
   localparam int XL  = 32;
   localparam int NL  = 8;
   localparam int NRB = 6;
   localparam int UW  = 44;
   localparam int WW  = 2;
   localparam int PCB = 30;
   localparam int LW  = NT * XL;
   localparam int LB  = $clog2(NL);

   typedef struct {
      logic [LB-1:0]  lane;
      logic [LW-1:0]  data;
      logic           sop;
      logic           eop;
      logic [LB-1:0]  last;
      logic [NRB-1:0] vd;
      logic [UW-1:0]  uuid;
      logic [WW-1:0]  wis;
      logic [NT-1:0]  tmask;
      logic [PCB-1:0] pc;
   } beat_t;

   logic             clk;
   logic             reset;
   logic             vec_in_valid;
   logic             vec_in_ready;
   logic [UW-1:0]    vec_in_uuid;
   logic [WW-1:0]    vec_in_wis;
   logic [NT-1:0]    vec_in_tmask;
   logic [PCB-1:0]   vec_in_PC;
   logic [NRB-1:0]   vec_in_vd;
   logic [NL-1:0]    vec_in_lmask;
   logic [NL*LW-1:0] vec_in_data;
   logic             wb_stall;
   logic             wb_valid;
   logic [UW-1:0]    wb_uuid;
   logic [WW-1:0]    wb_wis;
   logic [NT-1:0]    wb_tmask;
   logic [PCB-1:0]   wb_PC;
   logic [NRB-1:0]   wb_rd;
   logic [LW-1:0]    wb_data;
   logic             wb_sop;
   logic             wb_eop;
   logic             wb_is_vec;
   logic [NRB-1:0]   wb_vd;
   logic [LB-1:0]    wb_vd_lane_id;
   logic [LB-1:0]    wb_vd_is_last;
`ifdef VX_VEC_WB_PERF_EN
   logic [31:0]      perf_beats;
   logic [31:0]      perf_stall_cycles;
`endif

   int    total = 0;
   int    bad   = 0;
   int    model_beats  = 0;
   int    model_stalls = 0;
   int    send_obs     = 0;
   beat_t exp_q[$];

   vx_vec_wb_serializer #(
      .NUM_THREADS(NT), .XLEN(XL), .NUM_LANES(NL), .NR_BITS(NRB),
      .UUID_WIDTH(UW), .ISSUE_WIS_W(WW), .PC_BITS(PCB)
   ) dut (
      .clk(clk), .reset(reset),
      .vec_in_valid(vec_in_valid), .vec_in_ready(vec_in_ready),
      .vec_in_uuid(vec_in_uuid), .vec_in_wis(vec_in_wis),
      .vec_in_tmask(vec_in_tmask), .vec_in_PC(vec_in_PC),
      .vec_in_vd(vec_in_vd), .vec_in_lmask(vec_in_lmask),
      .vec_in_data(vec_in_data), .wb_stall(wb_stall),
      .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wis(wb_wis),
      .wb_tmask(wb_tmask), .wb_PC(wb_PC), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_sop(wb_sop), .wb_eop(wb_eop),
      .wb_is_vec(wb_is_vec), .wb_vd(wb_vd),
      .wb_vd_lane_id(wb_vd_lane_id), .wb_vd_is_last(wb_vd_is_last)
`ifdef VX_VEC_WB_PERF_EN
      , .perf_beats(perf_beats), .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it when the values differ.
   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expand an accepted packet into its expected beats, ascending lane order.
   task automatic push_packet();
      beat_t b;
      int    hi;
      bit    first;
      hi    = 0;
      first = 1'b1;
      for (int l = 0; l < NL; l++) if (vec_in_lmask[l]) hi = l;
      for (int l = 0; l < NL; l++) begin
         if (vec_in_lmask[l]) begin
            b.lane  = LB'(l);
            b.data  = vec_in_data[l*LW +: LW];
            b.sop   = first;
            b.eop   = (l == hi);
            b.last  = LB'(hi);
            b.vd    = vec_in_vd;
            b.uuid  = vec_in_uuid;
            b.wis   = vec_in_wis;
            b.tmask = vec_in_tmask;
            b.pc    = vec_in_PC;
            exp_q.push_back(b);
            first = 1'b0;
         end
      end
   endtask

   // One clock cycle: drive fresh inputs, check outputs mid-cycle, update the model.
   task automatic step(input logic v, input logic [NL-1:0] lm, input logic st);
      logic  exp_valid;
      logic  exp_ready;
      beat_t b;
      vec_in_valid = v;
      vec_in_lmask = lm;
      wb_stall     = st;
      vec_in_uuid  = {12'($urandom), $urandom};
      vec_in_wis   = WW'($urandom);
      vec_in_tmask = NT'($urandom);
      vec_in_PC    = PCB'($urandom);
      vec_in_vd    = NRB'($urandom);
      for (int i = 0; i < NL * NT; i++) vec_in_data[i*XL +: XL] = $urandom;
      @(negedge clk);
      exp_valid = (exp_q.size() != 0) && !st;
      exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && !st);
      chk("wb_valid", LW'(wb_valid), LW'(exp_valid));
      chk("vec_in_ready", LW'(vec_in_ready), LW'(exp_ready));
      if (!vec_in_ready || wb_valid) send_obs++;
      if ((exp_q.size() != 0) && st) model_stalls++;
      if (exp_valid) begin
         b = exp_q.pop_front();
         model_beats++;
         chk("lane_id", LW'(wb_vd_lane_id), LW'(b.lane));
         chk("data", wb_data, b.data);
         chk("sop", LW'(wb_sop), LW'(b.sop));
         chk("eop", LW'(wb_eop), LW'(b.eop));
         chk("is_last", LW'(wb_vd_is_last), LW'(b.last));
         chk("vd", LW'(wb_vd), LW'(b.vd));
         chk("uuid", LW'(wb_uuid), LW'(b.uuid));
         chk("wis", LW'(wb_wis), LW'(b.wis));
         chk("tmask", LW'(wb_tmask), LW'(b.tmask));
         chk("pc", LW'(wb_PC), LW'(b.pc));
         chk("is_vec", LW'(wb_is_vec), LW'(1'b1));
         chk("rd", LW'(wb_rd), LW'(0));
      end else begin
         chk("idle_sop", LW'(wb_sop), LW'(0));
         chk("idle_eop", LW'(wb_eop), LW'(0));
      end
      if (v && exp_ready) push_packet();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int            s0;
      logic [NL-1:0] lm;
      reset        = 1'b0;
      vec_in_valid = 1'b0;
      vec_in_uuid  = '0;
      vec_in_wis   = '0;
      vec_in_tmask = '0;
      vec_in_PC    = '0;
      vec_in_vd    = '0;
      vec_in_lmask = '0;
      vec_in_data  = '0;
      wb_stall     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", LW'(wb_valid), LW'(0));
      chk("rst_ready", LW'(vec_in_ready), LW'(1));
      chk("rst_data", wb_data, LW'(0));
      chk("rst_uuid", LW'(wb_uuid), LW'(0));
      chk("rst_vd", LW'(wb_vd), LW'(0));
      chk("rst_lane", LW'(wb_vd_lane_id), LW'(0));
      chk("rst_last", LW'(wb_vd_is_last), LW'(0));
      chk("rst_sop", LW'(wb_sop), LW'(0));
`ifdef VX_VEC_WB_PERF_EN
      chk("rst_perf_beats", LW'(perf_beats), LW'(0));
`endif
      @(posedge clk);
      #1 reset = 1'b1;

      // Full mask, eight consecutive beats.
      step(1'b1, 8'hFF, 1'b0);
      repeat (8) step(1'b0, 8'h00, 1'b0);
      chk("full_drained", LW'(exp_q.size()), LW'(0));

      // Sparse mask, lanes 2, 5, 7.
      step(1'b1, 8'b1010_0100, 1'b0);
      repeat (4) step(1'b0, 8'h00, 1'b0);

      // Stall for three cycles on lane 1: seven cycles in SEND.
      step(1'b1, 8'h0F, 1'b0);
      s0 = send_obs;
      step(1'b0, 8'h00, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b1);
      repeat (4) step(1'b0, 8'h00, 1'b0);
      chk("stall_send_cycles", LW'(send_obs - s0), LW'(7));

      // Back-to-back: next packet offered on the eop beat.
      step(1'b1, 8'h03, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h81, 1'b0);
      chk("b2b_sop_next", LW'(wb_sop), LW'(1));
      repeat (3) step(1'b0, 8'h00, 1'b0);

      // Edge masks.
      step(1'b1, 8'h00, 1'b0);
      repeat (2) step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h80, 1'b0);
      repeat (2) step(1'b0, 8'h00, 1'b0);

      // Reset during beat 3 of 8.
      step(1'b1, 8'hFF, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("mid_beat3_lane", LW'(wb_vd_lane_id), LW'(2));
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", LW'(wb_valid), LW'(0));
      chk("mid_rst_eop", LW'(wb_eop), LW'(0));
      exp_q.delete();
      model_beats  = 0;
      model_stalls = 0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("mid_rel_ready", LW'(vec_in_ready), LW'(1));
`ifdef VX_VEC_WB_PERF_EN
      chk("mid_perf_beats", LW'(perf_beats), LW'(0));
`endif
      @(posedge clk);
      #1;

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0:       lm = 8'h00;
            1:       lm = 8'h01 << $urandom_range(0, NL - 1);
            default: lm = NL'($urandom);
         endcase
         step(1'($urandom_range(0, 2) != 0), lm, 1'($urandom_range(0, 3) == 0));
      end
      for (int n = 0; n < 40; n++) begin
         if (exp_q.size() != 0) step(1'b0, 8'h00, 1'b0);
      end
      chk("rand_drained", LW'(exp_q.size()), LW'(0));
`ifdef VX_VEC_WB_PERF_EN
      chk("perf_beats", LW'(perf_beats), LW'(model_beats));
      chk("perf_stalls", LW'(perf_stall_cycles), LW'(model_stalls));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
